// File: rtl/line_fetch_scheduler_if.sv
// ---------------------------------------------------------------------------
// line_fetch_scheduler_if
//   Bundles the two handshakes of the vertical line scheduler:
//     - fetch side : fetch_req / fetch_line / fetch_buf  -> line reader
//                    fetch_ack                          <- line reader
//     - output side: out_line_valid / out_line_number /
//                    out_top_buf / out_bot_buf / out_frac -> vertical filter
//                    out_line_ack                         <- vertical filter
//   modport master : the scheduler (drives requests, receives acks)
//   modport slave  : reader/filter side (drives acks, receives requests)
// ---------------------------------------------------------------------------
interface line_fetch_scheduler_if #(
    parameter int LINE_NUMBER_WIDTH = 16,
    parameter int FRAC_WIDTH        = 8
);
    logic                         fetch_req;
    logic [LINE_NUMBER_WIDTH-1:0] fetch_line;
    logic                         fetch_buf;
    logic                         fetch_ack;

    logic                         out_line_valid;
    logic                         out_line_ack;
    logic [LINE_NUMBER_WIDTH-1:0] out_line_number;
    logic                         out_top_buf;
    logic                         out_bot_buf;
    logic [FRAC_WIDTH-1:0]        out_frac;

    modport master (
        output fetch_req, fetch_line, fetch_buf,
        input  fetch_ack,
        output out_line_valid, out_line_number, out_top_buf, out_bot_buf, out_frac,
        input  out_line_ack
    );

    modport slave (
        input  fetch_req, fetch_line, fetch_buf,
        output fetch_ack,
        input  out_line_valid, out_line_number, out_top_buf, out_bot_buf, out_frac,
        output out_line_ack
    );
endinterface

// File: rtl/line_fetch_scheduler.sv
// ---------------------------------------------------------------------------
// line_fetch_scheduler
//   Vertical-scaling line scheduler. For each output line a fixed-point
//   source position (acc) selects a top source line s and a bottom line s+1
//   (both clamped to src-1). Source lines are fetched in order into a
//   two-slot ping-pong buffer (slot = line[0]) before each output line is
//   presented to the vertical filter together with its fraction.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   en                  global enable, 0 stalls everything
//   frame_start         one-cycle frame start pulse
//   cfg_src_lines       source lines per frame      (latched at frame start)
//   cfg_dst_lines       output lines per frame      (latched at frame start)
//   cfg_v_step          Q(LNW.FW) source step/line  (latched at frame start)
//   bus                 fetch and output-line handshakes (master side)
//   frame_done          one-cycle pulse when the frame completes
//   busy                high whenever not idle
//   resync_pulse        one-cycle pulse on a mid-frame restart
//                       (only with LINE_FETCH_SCHEDULER_RESYNC_EN)
//
// Build option
//   LINE_FETCH_SCHEDULER_RESYNC_EN : frame_start while busy restarts the
//   frame instead of being ignored.
// ---------------------------------------------------------------------------
module line_fetch_scheduler #(
    parameter int LINE_NUMBER_WIDTH = 16,
    parameter int FRAC_WIDTH        = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    en,
    input  logic                                    frame_start,
    input  logic [LINE_NUMBER_WIDTH-1:0]            cfg_src_lines,
    input  logic [LINE_NUMBER_WIDTH-1:0]            cfg_dst_lines,
    input  logic [LINE_NUMBER_WIDTH+FRAC_WIDTH-1:0] cfg_v_step,
    line_fetch_scheduler_if.master                  bus,
    output logic                                    frame_done,
`ifdef LINE_FETCH_SCHEDULER_RESYNC_EN
    output logic                                    resync_pulse,
`endif
    output logic                                    busy
);
    localparam int LNW = LINE_NUMBER_WIDTH;
    localparam int FW  = FRAC_WIDTH;
    localparam int AW  = LNW + FW + 1;   // one guard bit above the step range

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_EVAL    = 3'd1;
    localparam logic [2:0] S_FETCH   = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]        state;
    logic [LNW-1:0]    src_q;
    logic [LNW-1:0]    dst_q;
    logic [LNW+FW-1:0] step_q;
    logic [AW-1:0]     acc;
    logic [LNW-1:0]    next_fetch;
    logic [LNW-1:0]    out_cnt;

    // Position arithmetic. The clamps only matter once s reaches the last
    // source line; both are evaluated with one extra bit so s+1 cannot wrap.
    logic [LNW:0]   s_int;
    logic [LNW:0]   last_line;
    logic [LNW+1:0] s_plus;
    logic [LNW:0]   need_line;
    logic           top_clamp;
    logic           fetch_go;
    logic [AW:0]    acc_sum;
    logic [AW-1:0]  acc_next;
    logic           start_hit;
    logic           empty_cfg;

    assign s_int     = acc[AW-1:FW];
    assign last_line = {1'b0, src_q} - {{LNW{1'b0}}, 1'b1};
    assign s_plus    = {1'b0, s_int} + {{(LNW+1){1'b0}}, 1'b1};
    assign need_line = (s_plus >= {1'b0, last_line}) ? last_line : s_plus[LNW:0];
    assign top_clamp = (s_int >= last_line);
    // Lines are fetched strictly in order, so every line up to need_line
    // is resident once next_fetch passes it; line n only evicts n-2.
    assign fetch_go  = ({1'b0, next_fetch} <= need_line);

    assign acc_sum   = {1'b0, acc} + {2'b00, step_q};
    assign acc_next  = acc_sum[AW] ? {AW{1'b1}} : acc_sum[AW-1:0];

    assign empty_cfg = (cfg_src_lines == '0) || (cfg_dst_lines == '0);
`ifdef LINE_FETCH_SCHEDULER_RESYNC_EN
    assign start_hit = frame_start;
`else
    assign start_hit = frame_start && (state == S_IDLE);
`endif

    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            // NOTE: the config copies are reset too, so no output ever
            // depends on an undefined register after reset.
            state      <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            step_q     <= '0;
            acc        <= '0;
            next_fetch <= '0;
            out_cnt    <= '0;
`ifdef LINE_FETCH_SCHEDULER_RESYNC_EN
            resync_pulse <= 1'b0;
`endif
        end else begin
`ifdef LINE_FETCH_SCHEDULER_RESYNC_EN
            resync_pulse <= 1'b0;
`endif
            if (en) begin
                if (start_hit) begin
                    src_q      <= cfg_src_lines;
                    dst_q      <= cfg_dst_lines;
                    step_q     <= cfg_v_step;
                    acc        <= '0;
                    next_fetch <= '0;
                    out_cnt    <= '0;
                    // An empty frame has nothing to fetch or present.
                    state      <= empty_cfg ? S_DONE : S_EVAL;
`ifdef LINE_FETCH_SCHEDULER_RESYNC_EN
                    resync_pulse <= (state != S_IDLE);
`endif
                end else begin
                    case (state)
                        S_EVAL:    state <= fetch_go ? S_FETCH : S_PRESENT;
                        S_FETCH: begin
                            if (bus.fetch_ack) begin
                                next_fetch <= next_fetch + {{(LNW-1){1'b0}}, 1'b1};
                                state      <= S_EVAL;
                            end
                        end
                        S_PRESENT: begin
                            if (bus.out_line_ack) begin
                                acc     <= acc_next;
                                out_cnt <= out_cnt + {{(LNW-1){1'b0}}, 1'b1};
                                state   <= (out_cnt == dst_q - {{(LNW-1){1'b0}}, 1'b1})
                                           ? S_DONE : S_EVAL;
                            end
                        end
                        S_DONE:    state <= S_IDLE;
                        default:   state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    // Strobes are gated by en; data fields follow the state only, so they
    // are unchanged across a stall.
    assign bus.fetch_req       = en && (state == S_FETCH);
    assign bus.fetch_line      = (state == S_FETCH) ? next_fetch : '0;
    assign bus.fetch_buf       = (state == S_FETCH) && next_fetch[0];

    assign bus.out_line_valid  = en && (state == S_PRESENT);
    assign bus.out_line_number = (state == S_PRESENT) ? out_cnt : '0;
    assign bus.out_top_buf     = (state == S_PRESENT) &&
                                 (top_clamp ? last_line[0] : s_int[0]);
    assign bus.out_bot_buf     = (state == S_PRESENT) && need_line[0];
    assign bus.out_frac        = (state == S_PRESENT) ? acc[FW-1:0] : '0;

    assign frame_done          = en && (state == S_DONE);
    assign busy                = (state != S_IDLE);
endmodule

// File: tb/tb_line_fetch_scheduler.sv
// ---------------------------------------------------------------------------
// tb_line_fetch_scheduler
//   Self-checking bench. A reference model expands each frame's
//   configuration into the ordered list of fetch and present events using
//   plain integer arithmetic; the bench acks the DUT with random delays and
//   compares every accepted transaction against that list.
// ---------------------------------------------------------------------------
module tb_line_fetch_scheduler;
    localparam int LNW = 16;
    localparam int FW  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           frame_start;
    logic [LNW-1:0] cfg_src_lines;
    logic [LNW-1:0] cfg_dst_lines;
    logic [LNW+FW-1:0] cfg_v_step;
    logic           frame_done;
    logic           busy;
`ifdef LINE_FETCH_SCHEDULER_RESYNC_EN
    logic           resync_pulse;
`endif

    line_fetch_scheduler_if #(.LINE_NUMBER_WIDTH(LNW), .FRAC_WIDTH(FW)) bus ();

    line_fetch_scheduler #(.LINE_NUMBER_WIDTH(LNW), .FRAC_WIDTH(FW)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .frame_start   (frame_start),
        .cfg_src_lines (cfg_src_lines),
        .cfg_dst_lines (cfg_dst_lines),
        .cfg_v_step    (cfg_v_step),
        .bus           (bus),
        .frame_done    (frame_done),
`ifdef LINE_FETCH_SCHEDULER_RESYNC_EN
        .resync_pulse  (resync_pulse),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit is_fetch;
        int line;   // fetch: source line, present: output line index
        int top;    // present: top slot
        int bot;    // fetch: target slot, present: bottom slot
        int frac;
    } ev_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected event order for one frame, straight from the scheduling rules.
    task automatic build_model(input int src, input int dst, input longint step,
                               output ev_t q[$], output int n_fetch);
        longint acc = 0;
        longint sat = (longint'(1) << (LNW + FW + 1)) - 1;
        longint s, top, need;
        int nxt = 0;
        ev_t e;
        q = {};
        n_fetch = 0;
        if (src == 0 || dst == 0) return;
        for (int k = 0; k < dst; k++) begin
            s    = acc >> FW;
            top  = (s < src - 1) ? s : src - 1;
            need = (s + 1 < src - 1) ? s + 1 : src - 1;
            while (nxt <= need) begin
                e = '{is_fetch: 1'b1, line: nxt, top: 0, bot: nxt % 2, frac: 0};
                q.push_back(e);
                nxt++;
                n_fetch++;
            end
            e = '{is_fetch: 1'b0, line: k, top: int'(top % 2), bot: int'(need % 2),
                  frac: int'(acc % (1 << FW))};
            q.push_back(e);
            acc = (acc + step > sat) ? sat : acc + step;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_fetch_req"},  64'(bus.fetch_req),       64'd0);
        check({tag, "_fetch_line"}, 64'(bus.fetch_line),      64'd0);
        check({tag, "_fetch_buf"},  64'(bus.fetch_buf),       64'd0);
        check({tag, "_valid"},      64'(bus.out_line_valid),  64'd0);
        check({tag, "_number"},     64'(bus.out_line_number), 64'd0);
        check({tag, "_top"},        64'(bus.out_top_buf),     64'd0);
        check({tag, "_bot"},        64'(bus.out_bot_buf),     64'd0);
        check({tag, "_frac"},       64'(bus.out_frac),        64'd0);
        check({tag, "_done"},       64'(frame_done),          64'd0);
        check({tag, "_busy"},       64'(busy),                64'd0);
    endtask

    // Runs one frame with random ack delays. Inputs change and outputs are
    // sampled on the falling edge only.
    task automatic run_frame(input string tag, input int src, input int dst,
                             input longint step, input bit stall, input bit midstart);
        ev_t q[$];
        ev_t e;
        int  n_fetch, fetches = 0, dones = 0;
        bit  stalled = 1'b0, mid_done = 1'b0;
        build_model(src, dst, step, q, n_fetch);
        @(negedge clk);
        en            = 1'b1;
        cfg_src_lines = LNW'(src);
        cfg_dst_lines = LNW'(dst);
        cfg_v_step    = (LNW+FW)'(step);
        frame_start   = 1'b1;
        @(negedge clk);
        frame_start   = 1'b0;
        for (int cyc = 0; cyc < 4000 && dones == 0; cyc++) begin
            frame_start  = 1'b0;
            bus.fetch_ack    = 1'b0;
            bus.out_line_ack = 1'b0;
            if (frame_done) begin
                dones++;
            end else if (bus.fetch_req) begin
                if (stall && !stalled && bus.fetch_line == 2) begin
                    stalled = 1'b1;
                    en = 1'b0;
                    for (int i = 0; i < 5; i++) begin
                        @(negedge clk);
                        check({tag, "_stall_req"},   64'(bus.fetch_req),      64'd0);
                        check({tag, "_stall_valid"}, 64'(bus.out_line_valid), 64'd0);
                        bus.fetch_ack = (i == 2);
                    end
                    bus.fetch_ack = 1'b0;
                    en = 1'b1;
                end else if ($urandom_range(0, 2) != 0) begin
                    if (q.size() == 0) begin
                        check({tag, "_extra_fetch"}, 64'(bus.fetch_line), 64'hFFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        check({tag, "_is_fetch"},   64'(1), 64'(e.is_fetch));
                        check({tag, "_fetch_line"}, 64'(bus.fetch_line), 64'(e.line));
                        check({tag, "_fetch_buf"},  64'(bus.fetch_buf),  64'(e.bot));
                    end
                    bus.fetch_ack = 1'b1;
                    fetches++;
                end
            end else if (bus.out_line_valid) begin
                if (midstart && !mid_done && bus.out_line_number == 1) begin
                    mid_done    = 1'b1;
                    frame_start = 1'b1;
                end else if ($urandom_range(0, 2) != 0) begin
                    if (q.size() == 0) begin
                        check({tag, "_extra_line"}, 64'(bus.out_line_number), 64'hFFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        check({tag, "_is_present"}, 64'(0), 64'(e.is_fetch));
                        check({tag, "_line_num"}, 64'(bus.out_line_number), 64'(e.line));
                        check({tag, "_top_buf"},  64'(bus.out_top_buf), 64'(e.top));
                        check({tag, "_bot_buf"},  64'(bus.out_bot_buf), 64'(e.bot));
                        check({tag, "_frac"},     64'(bus.out_frac),    64'(e.frac));
                    end
                    bus.out_line_ack = 1'b1;
                end
            end
            @(negedge clk);
        end
        bus.fetch_ack    = 1'b0;
        bus.out_line_ack = 1'b0;
        check({tag, "_done_seen"},   64'(dones),    64'd1);
        check({tag, "_left_events"}, 64'(q.size()), 64'd0);
        check({tag, "_fetch_count"}, 64'(fetches),  64'(n_fetch));
        check({tag, "_done_once"},   64'(frame_done), 64'd0);
        check({tag, "_idle"},        64'(busy),       64'd0);
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        frame_start = 1'b0;
        cfg_src_lines = '0;
        cfg_dst_lines = '0;
        cfg_v_step = '0;
        bus.fetch_ack = 1'b0;
        bus.out_line_ack = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // Directed frames from the plan.
        run_frame("t1_unity",  4, 4, 'h100, 1'b0, 1'b0);
        run_frame("t2_upscale", 2, 4, 'h080, 1'b0, 1'b0);
        run_frame("t3_down",   8, 4, 'h200, 1'b0, 1'b0);
        run_frame("t4_stall",  6, 4, 'h100, 1'b1, 1'b0);

        // Empty frame: the pulse appears in the cycle following the start edge.
        @(negedge clk);
        en = 1'b1;
        cfg_src_lines = 16'd4;
        cfg_dst_lines = 16'd0;
        cfg_v_step = 24'h000100;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("t5_done_pulse", 64'(frame_done), 64'd1);
        check("t5_no_fetch",   64'(bus.fetch_req), 64'd0);
        check("t5_no_valid",   64'(bus.out_line_valid), 64'd0);
        @(negedge clk);
        check("t5_done_drop",  64'(frame_done), 64'd0);
        check("t5_idle",       64'(busy), 64'd0);

        // Reset in the middle of presenting output line 1.
        @(negedge clk);
        cfg_src_lines = 16'd4;
        cfg_dst_lines = 16'd4;
        cfg_v_step = 24'h000100;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        begin
            bit hit = 1'b0;
            for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
                bus.fetch_ack    = bus.fetch_req;
                bus.out_line_ack = bus.out_line_valid && (bus.out_line_number != 1);
                hit = bus.out_line_valid && (bus.out_line_number == 1);
                if (!hit) @(negedge clk);
            end
            check("t6_reached_line1", 64'(hit), 64'd1);
        end
        bus.fetch_ack = 1'b0;
        bus.out_line_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_idle("t6_after_rst");
        rst = 1'b0;
        run_frame("t6_restart", 4, 4, 'h100, 1'b0, 1'b0);
`ifndef LINE_FETCH_SCHEDULER_RESYNC_EN
        run_frame("t6_midstart", 4, 4, 'h100, 1'b0, 1'b1);
`endif

        // Saturating accumulator with a clamped last line.
        run_frame("sat_step", 3, 4, 'hFF_FFFF, 1'b0, 1'b0);
        run_frame("src_one",  1, 3, 'h0C0, 1'b0, 1'b0);

        // Random configurations.
        for (int n = 0; n < 8; n++) begin
            run_frame("rand", $urandom_range(1, 12), $urandom_range(1, 12),
                      longint'($urandom_range('h020, 'h300)), 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
